// File: rtl/qqvga_line_fetch.sv
`default_nettype none
// +--------------------------------------------------------------------------------------+
// | qqvga_line_fetch: ping-pong line prefetch, 2x upscaled image in lower-right quadrant |
// | Rev 1.0 -- optional test-pattern source enabled by defining LINE_FETCH_TESTPAT_EN     |
// +--------------------------------------------------------------------------------------+
module qqvga_line_fetch #(
  parameter int IMG_WIDTH  = 160,
  parameter int IMG_HEIGHT = 120,
  parameter int RD_LATENCY = 1,
  parameter int FETCH_X    = 640
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        DE,
  input  logic [9:0]  x_pixel,
  input  logic [9:0]  y_pixel,
  output logic        fb_rd_en,
  output logic [14:0] fb_rd_addr,
  input  logic [11:0] fb_rd_data,
  output logic        DE_o,
  output logic [9:0]  x_pixel_o,
  output logic [9:0]  y_pixel_o,
  output logic [3:0]  r_out,
  output logic [3:0]  g_out,
  output logic [3:0]  b_out,
  output logic        fetch_overrun
`ifdef LINE_FETCH_TESTPAT_EN
  ,
  input  logic        testpat
`endif
);

  localparam int LBUF_DEPTH = 2 * IMG_WIDTH;
  localparam int LBUF_AW    = $clog2(LBUF_DEPTH);
  localparam int Y_FIRST    = 239;
  localparam int Y_LAST     = Y_FIRST + 2 * (IMG_HEIGHT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_nx;
  logic [7:0]  col;
  logic [6:0]  line;
  logic [6:0]  line_trig;
  logic [1:0]  drain_cnt;
  logic        trigger;
  logic        fetching;
  logic        tp;
  logic [14:0] addr_cur;
  logic [14:0] addr_hold;

`ifdef LINE_FETCH_TESTPAT_EN
  assign tp = testpat;
`else
  assign tp = 1'b0;
`endif

  // y odd <=> (y+1-240) even; the source line is (y-239)/2
  assign trigger   = (x_pixel == 10'(FETCH_X)) && (y_pixel >= 10'(Y_FIRST)) &&
                     (y_pixel <= 10'(Y_LAST)) && y_pixel[0];
  assign line_trig = 7'((y_pixel - 10'(Y_FIRST)) >> 1);
  assign addr_cur  = 15'(line) * 15'(IMG_WIDTH) + 15'(col);

  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (trigger) state_nx = S_FETCH;
      S_FETCH: if (col == 8'(IMG_WIDTH - 1)) state_nx = S_DRAIN;
      S_DRAIN: if (drain_cnt == 2'(RD_LATENCY - 1)) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    fetching   = 1'b0;
    fb_rd_en   = 1'b0;
    fb_rd_addr = addr_hold;
    if (state == S_FETCH) begin
      fetching = 1'b1;
      fb_rd_en = ~tp;
      if (!tp) fb_rd_addr = addr_cur;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      col           <= '0;
      line          <= '0;
      drain_cnt     <= '0;
      addr_hold     <= '0;
      fetch_overrun <= 1'b0;
    end else begin
      if (state == S_IDLE && trigger) begin
        col  <= '0;
        line <= line_trig;
      end
      if (state == S_FETCH) begin
        col       <= col + 8'd1;
        drain_cnt <= '0;
      end
      if (state == S_DRAIN) drain_cnt <= drain_cnt + 2'd1;
      if (fb_rd_en) addr_hold <= addr_cur;
      if (trigger && state != S_IDLE) fetch_overrun <= 1'b1;
    end
  end

  // Each strobe travels RD_LATENCY clocks with its column and bank to meet its data
  logic       pipe_v    [RD_LATENCY];
  logic       pipe_bank [RD_LATENCY];
  logic [7:0] pipe_col  [RD_LATENCY];
`ifdef LINE_FETCH_TESTPAT_EN
  logic        pipe_tp  [RD_LATENCY];
  logic [11:0] pipe_pat [RD_LATENCY];
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipe_v[i]    <= 1'b0;
        pipe_bank[i] <= 1'b0;
        pipe_col[i]  <= '0;
`ifdef LINE_FETCH_TESTPAT_EN
        pipe_tp[i]   <= 1'b0;
        pipe_pat[i]  <= '0;
`endif
      end
    end else begin
      pipe_v[0]    <= fetching;
      pipe_bank[0] <= line[0];
      pipe_col[0]  <= col;
`ifdef LINE_FETCH_TESTPAT_EN
      pipe_tp[0]   <= tp;
      pipe_pat[0]  <= {col[7:4], line[6:3], 4'hF};
`endif
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipe_v[i]    <= pipe_v[i-1];
        pipe_bank[i] <= pipe_bank[i-1];
        pipe_col[i]  <= pipe_col[i-1];
`ifdef LINE_FETCH_TESTPAT_EN
        pipe_tp[i]   <= pipe_tp[i-1];
        pipe_pat[i]  <= pipe_pat[i-1];
`endif
      end
    end
  end

  logic [LBUF_AW-1:0] wr_addr;
  logic [11:0]        wr_data;
  logic [11:0]        lbuf [LBUF_DEPTH];

  assign wr_addr = (pipe_bank[RD_LATENCY-1] ? LBUF_AW'(IMG_WIDTH) : '0) +
                   LBUF_AW'(pipe_col[RD_LATENCY-1]);
`ifdef LINE_FETCH_TESTPAT_EN
  assign wr_data = pipe_tp[RD_LATENCY-1] ? pipe_pat[RD_LATENCY-1] : fb_rd_data;
`else
  assign wr_data = fb_rd_data;
`endif

  always_ff @(posedge clk) begin
    if (pipe_v[RD_LATENCY-1]) lbuf[wr_addr] <= wr_data;
  end

  logic [8:0]         disp_col;
  logic               disp_bank;
  logic               show;
  logic [LBUF_AW-1:0] rd_addr;
  logic [11:0]        rd_q;
  logic               show_q;

  assign disp_col  = 9'((x_pixel - 10'd320) >> 1);
  assign disp_bank = 1'((y_pixel - 10'd240) >> 1);
  assign show      = DE && (x_pixel >= 10'd320) && (y_pixel >= 10'd240);
  assign rd_addr   = (disp_col < 9'(IMG_WIDTH)) ?
                     (disp_bank ? LBUF_AW'(IMG_WIDTH) : '0) + LBUF_AW'(disp_col) : '0;

  always_ff @(posedge clk) begin
    rd_q <= lbuf[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      show_q    <= 1'b0;
      DE_o      <= 1'b0;
      x_pixel_o <= '0;
      y_pixel_o <= '0;
    end else begin
      show_q    <= show;
      DE_o      <= DE;
      x_pixel_o <= x_pixel;
      y_pixel_o <= y_pixel;
    end
  end

  assign r_out = show_q ? rd_q[11:8] : 4'h0;
  assign g_out = show_q ? rd_q[7:4]  : 4'h0;
  assign b_out = show_q ? rd_q[3:0]  : 4'h0;

endmodule
`default_nettype wire
